// File: rtl/sram_pkg.sv
// sram_pkg: shared definitions for the SRAM bus masters (writer, background
// fetcher, arbiter).
//   - sram_state_e : write-master FSM states
//   - SRAM_ADDR_W / SRAM_DATA_W : SRAM geometry (256K x 16)
//   - DEF_* : default write-cycle timing and FIFO depth
//   - sram_req_t : packed write request {addr, data, byteEn}
//   - lane_mask() : expands a 2-bit byte enable into a 16-bit bit mask
package sram_pkg;

    localparam int SRAM_ADDR_W      = 18;
    localparam int SRAM_DATA_W      = 16;

    localparam int DEF_FIFO_DEPTH   = 4;
    localparam int DEF_SETUP_CYCLES = 1;
    localparam int DEF_WE_CYCLES    = 2;
    localparam int DEF_HOLD_CYCLES  = 1;
    localparam int READ_CYCLES      = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_READ
    } sram_state_e;

    typedef struct packed {
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] data;
        logic [1:0]             byteEn;  // [1] high byte, [0] low byte
    } sram_req_t;

    function automatic logic [SRAM_DATA_W-1:0] lane_mask(input logic [1:0] be);
        return {{8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/sram_wr_fifo.sv
// sram_wr_fifo: synchronous request FIFO for the SRAM write master.
// The head entry is read straight out of the storage flops (first-word
// fall-through), so dout_o is valid whenever empty_o is low.
// Ports:
//   clk, rstN   : clock, asynchronous active-low reset (pointers/count only)
//   push_i      : write din_i; ignored while full
//   din_i       : request to store
//   pop_i       : discard the head entry; ignored while empty
//   dout_o      : head entry
//   full_o      : no free entry
//   empty_o     : no stored entry
module sram_wr_fifo
    import sram_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic      clk,
    input  logic      rstN,
    input  logic      push_i,
    input  sram_req_t din_i,
    input  logic      pop_i,
    output sram_req_t dout_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int             PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int             CNT_W    = PTR_W + 1;
    localparam logic [CNT_W:0] FULL_EXT = CNT_W'(DEPTH);

    sram_req_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == FULL_EXT[PTR_W:0]);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/sram_writer.sv
// sram_writer: write-side master for the shared 256K x 16 asynchronous SRAM.
// Requests arrive over a valid/ready handshake, are buffered in
// sram_wr_fifo, and are turned into timed SETUP / PULSE / HOLD write cycles
// once the arbiter grants the bus. All SRAM pins are driven from flops.
//
// Optional feature macro: SRAM_WRITER_READBACK_EN
//   defined   : every write is followed by a 2-cycle READ that checks the
//               enabled byte lanes and sets the sticky verifyErr on mismatch
//   undefined : no READ state, ram_din ignored, verifyErr tied low
//
// Ports:
//   clk, rstN          : clock, asynchronous active-low reset
//   wrValid/wrReady    : request handshake (wrReady = FIFO not full)
//   wrAddr/wrData/wrByteEn : request payload; byteEn 00 is dropped
//   busReq/busGrant    : arbiter request / grant
//   busy               : FIFO non-empty or write cycle in progress
//   ram_addr/ram_dout  : SRAM address and write data
//   ramDrive           : tristate enable for ram_dout
//   ram_din            : SRAM read data (readback only)
//   ram_ce/oe/we/lb/hb : active-low SRAM strobes
//   verifyErr          : sticky readback mismatch flag
module sram_writer
    import sram_pkg::*;
#(
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
    parameter int WE_CYCLES    = DEF_WE_CYCLES,
    parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic                   wrValid,
    output logic                   wrReady,
    input  logic [SRAM_ADDR_W-1:0] wrAddr,
    input  logic [SRAM_DATA_W-1:0] wrData,
    input  logic [1:0]             wrByteEn,
    output logic                   busReq,
    input  logic                   busGrant,
    output logic                   busy,
    output logic [SRAM_ADDR_W-1:0] ram_addr,
    output logic [SRAM_DATA_W-1:0] ram_dout,
    output logic                   ramDrive,
    input  logic [SRAM_DATA_W-1:0] ram_din,
    output logic                   ram_ce,
    output logic                   ram_oe,
    output logic                   ram_we,
    output logic                   ram_lb,
    output logic                   ram_hb,
    output logic                   verifyErr
);

    localparam logic [2:0] SETUP_LOAD = 3'(SETUP_CYCLES - 1);
    localparam logic [2:0] WE_LOAD    = 3'(WE_CYCLES - 1);
    localparam logic [2:0] HOLD_LOAD  = 3'(HOLD_CYCLES - 1);

    sram_req_t              fifo_din;
    sram_req_t              head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;
    logic                   start;
    logic                   head_drop;
    logic                   head_ready;
    logic                   stage_last;
    logic                   cycle_end;

    sram_state_e            state_q;
    logic [2:0]             cnt_q;
    logic [SRAM_ADDR_W-1:0] ram_addr_q;
    logic [SRAM_DATA_W-1:0] ram_dout_q;
    logic                   ramDrive_q;
    logic                   ram_ce_q;
    logic                   ram_oe_q;
    logic                   ram_we_q;
    logic                   ram_lb_q;
    logic                   ram_hb_q;

    assign fifo_din = '{addr: wrAddr, data: wrData, byteEn: wrByteEn};

    sram_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstN    (rstN),
        .push_i  (wrValid),
        .din_i   (fifo_din),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign wrReady    = !fifo_full;
    assign head_drop  = !fifo_empty && (head.byteEn == 2'b00);
    assign head_ready = !fifo_empty && (head.byteEn != 2'b00) && busGrant;
    assign stage_last = (cnt_q == 3'd0);

`ifdef SRAM_WRITER_READBACK_EN
    assign cycle_end = (state_q == ST_READ) && stage_last;
`else
    assign cycle_end = (state_q == ST_HOLD) && stage_last;
`endif

    // A new cycle may start from IDLE or straight out of the last cycle of
    // the previous one. Empty-lane requests are only discarded from IDLE, so
    // such a head ends a back-to-back run and is dropped on the next cycle.
    always_comb begin
        start = 1'b0;
        pop   = 1'b0;
        if (state_q == ST_IDLE) begin
            start = head_ready;
            pop   = head_ready || head_drop;
        end else if (cycle_end) begin
            start = head_ready;
            pop   = head_ready;
        end
    end

    assign busReq = (state_q != ST_IDLE) || !fifo_empty;
    assign busy   = (state_q != ST_IDLE) || !fifo_empty;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            ram_addr_q <= '0;
            ram_dout_q <= '0;
            ramDrive_q <= 1'b0;
            ram_ce_q   <= 1'b1;
            ram_oe_q   <= 1'b1;
            ram_we_q   <= 1'b1;
            ram_lb_q   <= 1'b1;
            ram_hb_q   <= 1'b1;
        end else if (start) begin
            // Start overrides the per-state handling below, which covers both
            // IDLE entry and the back-to-back hand-over.
            state_q    <= ST_SETUP;
            cnt_q      <= SETUP_LOAD;
            ram_addr_q <= head.addr;
            ram_dout_q <= head.data;
            ramDrive_q <= 1'b1;
            ram_ce_q   <= 1'b0;
            ram_oe_q   <= 1'b1;
            ram_we_q   <= 1'b1;
            ram_lb_q   <= ~head.byteEn[0];
            ram_hb_q   <= ~head.byteEn[1];
        end else begin
            case (state_q)
                ST_SETUP: begin
                    if (stage_last) begin
                        state_q  <= ST_PULSE;
                        cnt_q    <= WE_LOAD;
                        ram_we_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                ST_PULSE: begin
                    if (stage_last) begin
                        state_q  <= ST_HOLD;
                        cnt_q    <= HOLD_LOAD;
                        ram_we_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                ST_HOLD: begin
                    if (stage_last) begin
`ifdef SRAM_WRITER_READBACK_EN
                        // Release the data bus and open the output buffers,
                        // keeping ce and the lane selects of the write.
                        state_q    <= ST_READ;
                        cnt_q      <= 3'(READ_CYCLES - 1);
                        ramDrive_q <= 1'b0;
                        ram_oe_q   <= 1'b0;
`else
                        state_q    <= ST_IDLE;
                        ramDrive_q <= 1'b0;
                        ram_ce_q   <= 1'b1;
                        ram_lb_q   <= 1'b1;
                        ram_hb_q   <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
`ifdef SRAM_WRITER_READBACK_EN
                ST_READ: begin
                    if (stage_last) begin
                        state_q    <= ST_IDLE;
                        ramDrive_q <= 1'b0;
                        ram_ce_q   <= 1'b1;
                        ram_oe_q   <= 1'b1;
                        ram_lb_q   <= 1'b1;
                        ram_hb_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
`endif
                default: begin
                    state_q <= state_q;
                end
            endcase
        end
    end

`ifdef SRAM_WRITER_READBACK_EN
    logic verify_err_q;

    // ram_din is sampled at the end of the second READ cycle; only the lanes
    // that were written take part in the comparison.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            verify_err_q <= 1'b0;
        end else if ((state_q == ST_READ) && stage_last &&
                     (((ram_din ^ ram_dout_q) & lane_mask(~{ram_hb_q, ram_lb_q})) != '0)) begin
            verify_err_q <= 1'b1;
        end
    end

    assign verifyErr = verify_err_q;
`else
    logic [SRAM_DATA_W-1:0] unused_din;
    assign unused_din = ram_din;
    assign verifyErr  = 1'b0;
`endif

    assign ram_addr = ram_addr_q;
    assign ram_dout = ram_dout_q;
    assign ramDrive = ramDrive_q;
    assign ram_ce   = ram_ce_q;
    assign ram_oe   = ram_oe_q;
    assign ram_we   = ram_we_q;
    assign ram_lb   = ram_lb_q;
    assign ram_hb   = ram_hb_q;

endmodule

// File: tb/tb_sram_writer.sv
// tb_sram_writer: self-checking bench for sram_writer (default parameters).
// Accepted requests are queued as expected SRAM writes; a negedge monitor
// turns every observed ram_we pulse into a write record, and each test
// compares the two queues.
module tb_sram_writer;
    import sram_pkg::*;

`ifdef SRAM_WRITER_READBACK_EN
    localparam int RB = 2;
`else
    localparam int RB = 0;
`endif

    typedef struct packed {
        logic [17:0] addr;
        logic [15:0] data;
        logic        lb;
        logic        hb;
        logic [3:0]  wecnt;
    } wr_rec_t;

    logic        clk;
    logic        rstN;
    logic        wrValid;
    logic        wrReady;
    logic [17:0] wrAddr;
    logic [15:0] wrData;
    logic [1:0]  wrByteEn;
    logic        busReq;
    logic        busGrant;
    logic        busy;
    logic [17:0] ram_addr;
    logic [15:0] ram_dout;
    logic        ramDrive;
    logic [15:0] ram_din;
    logic        ram_ce;
    logic        ram_oe;
    logic        ram_we;
    logic        ram_lb;
    logic        ram_hb;
    logic        verifyErr;

    wr_rec_t     exp_q[$];
    wr_rec_t     obs_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          ce_low_cnt = 0;
    int          we_run = 0;
    logic        oe_drive_bad = 1'b0;
    logic [15:0] sram_word = 16'h0000;
`ifdef SRAM_WRITER_READBACK_EN
    logic [15:0] din_xor = 16'h0000;
`else
    logic [15:0] din_xor = 16'h0100;
`endif

    sram_writer dut (
        .clk       (clk),
        .rstN      (rstN),
        .wrValid   (wrValid),
        .wrReady   (wrReady),
        .wrAddr    (wrAddr),
        .wrData    (wrData),
        .wrByteEn  (wrByteEn),
        .busReq    (busReq),
        .busGrant  (busGrant),
        .busy      (busy),
        .ram_addr  (ram_addr),
        .ram_dout  (ram_dout),
        .ramDrive  (ramDrive),
        .ram_din   (ram_din),
        .ram_ce    (ram_ce),
        .ram_oe    (ram_oe),
        .ram_we    (ram_we),
        .ram_lb    (ram_lb),
        .ram_hb    (ram_hb),
        .verifyErr (verifyErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-word SRAM model: remembers the last written word, returns it
    // optionally corrupted.
    assign ram_din = sram_word ^ din_xor;

    always @(negedge clk) begin
        if (!ram_ce && !ram_we) sram_word = ram_dout;
        if (!ram_ce) ce_low_cnt++;
        if (!ram_oe && ramDrive) oe_drive_bad = 1'b1;
        if (!ram_we) begin
            we_run++;
        end else if (we_run != 0) begin
            obs_q.push_back('{ram_addr, ram_dout, ram_lb, ram_hb, 4'(we_run)});
            we_run = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic [17:0] a, input logic [15:0] d,
                            input logic [1:0] be, output logic acc);
        wrValid  = 1'b1;
        wrAddr   = a;
        wrData   = d;
        wrByteEn = be;
        acc      = wrReady;
        tick();
        wrValid  = 1'b0;
        if (acc && be != 2'b00) exp_q.push_back('{a, d, ~be[0], ~be[1], 4'd2});
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) tick();
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        tick();
        tick();
        n_vec++;
        if ({wrReady, busReq, busy, ramDrive} !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_ctrl: rdy/req/busy/drive=%b want 1000", {wrReady, busReq, busy, ramDrive});
        end
        n_vec++;
        if ({ram_addr, ram_dout} !== 34'h0) begin
            n_err++;
            $display("FAIL reset_bus: addr=%h dout=%h want 0/0", ram_addr, ram_dout);
        end
        n_vec++;
        if ({ram_ce, ram_oe, ram_we, ram_lb, ram_hb, verifyErr} !== 6'b111110) begin
            n_err++;
            $display("FAIL reset_strobes: ce,oe,we,lb,hb,err=%b want 111110",
                     {ram_ce, ram_oe, ram_we, ram_lb, ram_hb, verifyErr});
        end
        rstN = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        logic acc;
        wr_rec_t e, o;
        busGrant = 1'b1;
        push_req(18'h01234, 16'hBEEF, 2'b11, acc);
        n_vec++;
        if ({busReq, ram_ce} !== 2'b11) begin
            n_err++;
            $display("FAIL single_req: busReq,ce=%b want 11", {busReq, ram_ce});
        end
        tick();
        n_vec++;
        if ({ram_ce, ramDrive, ram_we, ram_oe, ram_lb, ram_hb} !== 6'b011100 ||
            ram_addr !== 18'h01234 || ram_dout !== 16'hBEEF) begin
            n_err++;
            $display("FAIL single_setup: ce,drv,we,oe,lb,hb=%b addr=%h dout=%h want 011100 01234 beef",
                     {ram_ce, ramDrive, ram_we, ram_oe, ram_lb, ram_hb}, ram_addr, ram_dout);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++;
            if ({ram_we, ram_ce, ramDrive} !== 3'b001) begin
                n_err++;
                $display("FAIL single_pulse%0d: we,ce,drv=%b want 001", i, {ram_we, ram_ce, ramDrive});
            end
        end
        tick();
        n_vec++;
        if ({ram_we, ram_ce, ramDrive, busReq} !== 4'b1011) begin
            n_err++;
            $display("FAIL single_hold: we,ce,drv,req=%b want 1011", {ram_we, ram_ce, ramDrive, busReq});
        end
        for (int i = 0; i < RB; i++) begin
            tick();
            n_vec++;
            if ({ram_oe, ramDrive, ram_ce} !== 3'b000) begin
                n_err++;
                $display("FAIL single_read%0d: oe,drv,ce=%b want 000", i, {ram_oe, ramDrive, ram_ce});
            end
        end
        tick();
        n_vec++;
        if ({busReq, busy, ram_ce, ramDrive, verifyErr} !== 5'b00100) begin
            n_err++;
            $display("FAIL single_end: req,busy,ce,drv,err=%b want 00100",
                     {busReq, busy, ram_ce, ramDrive, verifyErr});
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL single_sb: no write seen, want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL single_sb: got %h want %h", o, e);
                end
            end
        end
        n_vec++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL single_extra: %0d unexpected writes, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_grant_withheld();
        logic acc;
        int run;
        wr_rec_t e, o;
        busGrant = 1'b0;
        for (int i = 0; i < 3; i++) push_req(18'h10 + 18'(i), 16'hA000 + 16'(i), 2'b11, acc);
        for (int i = 0; i < 5; i++) tick();
        n_vec++;
        if ({ram_ce, ram_we, busReq, busy} !== 4'b1111 || obs_q.size() != 0) begin
            n_err++;
            $display("FAIL withheld_idle: ce,we,req,busy=%b writes=%0d want 1111 0",
                     {ram_ce, ram_we, busReq, busy}, obs_q.size());
        end
        busGrant = 1'b1;
        for (int i = 0; i < 10 && ram_ce; i++) tick();
        run = 0;
        while (!ram_ce && run < 60) begin
            run++;
            tick();
        end
        n_vec++;
        if (run != 3 * (4 + RB)) begin
            n_err++;
            $display("FAIL withheld_b2b: ce low for %0d cycles want %0d", run, 3 * (4 + RB));
        end
        wait_idle(50);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL withheld_sb: no write seen, want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL withheld_sb: got %h want %h", o, e);
                end
            end
        end
        n_vec++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL withheld_extra: %0d unexpected writes, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_fifo_full();
        logic acc;
        wr_rec_t e, o;
        busGrant = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_req(18'h200 + 18'(i), 16'h5500 + 16'(i), 2'b11, acc);
            n_vec++;
            if (acc !== (i < 4)) begin
                n_err++;
                $display("FAIL full_accept%0d: ready=%b want %b", i, acc, (i < 4));
            end
        end
        n_vec++;
        if (wrReady !== 1'b0) begin
            n_err++;
            $display("FAIL full_ready: wrReady=%b want 0", wrReady);
        end
        busGrant = 1'b1;
        tick();
        n_vec++;
        if ({wrReady, ram_ce} !== 2'b10) begin
            n_err++;
            $display("FAIL full_firstpop: ready,ce=%b want 10", {wrReady, ram_ce});
        end
        for (int i = 0; i < 3 + RB; i++) tick();
        // Last cycle of the write: the push below meets the back-to-back pop.
        wrValid  = 1'b1;
        wrAddr   = 18'h3_0000;
        wrData   = 16'hC0DE;
        wrByteEn = 2'b11;
        tick();
        exp_q.push_back('{18'h3_0000, 16'hC0DE, 1'b0, 1'b0, 4'd2});
        n_vec++;
        if (wrReady !== 1'b1) begin
            n_err++;
            $display("FAIL full_pushpop: wrReady=%b want 1", wrReady);
        end
        wrAddr = 18'h3_0001;
        wrData = 16'hD00D;
        tick();
        wrValid = 1'b0;
        exp_q.push_back('{18'h3_0001, 16'hD00D, 1'b0, 1'b0, 4'd2});
        n_vec++;
        if (wrReady !== 1'b0) begin
            n_err++;
            $display("FAIL full_refill: wrReady=%b want 0", wrReady);
        end
        wait_idle(200);
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL full_drain: busy=%b want 0", busy);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL full_sb: no write seen, want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL full_sb: got %h want %h", o, e);
                end
            end
        end
        n_vec++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL full_extra: %0d unexpected writes, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_byte_lanes();
        logic acc;
        int c0;
        wr_rec_t e, o;
        busGrant = 1'b1;
        push_req(18'h2AAAA, 16'h12AB, 2'b10, acc);
        for (int i = 0; i < 10 && ram_ce; i++) tick();
        n_vec++;
        if ({ram_ce, ram_hb, ram_lb} !== 3'b001) begin
            n_err++;
            $display("FAIL lanes_hi: ce,hb,lb=%b want 001", {ram_ce, ram_hb, ram_lb});
        end
        wait_idle(50);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL lanes_sb: no write seen, want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL lanes_sb: got %h want %h", o, e);
                end
            end
        end
        c0 = ce_low_cnt;
        push_req(18'h00077, 16'hFFFF, 2'b00, acc);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL drop_busy: busy=%b want 1", busy);
        end
        tick();
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL drop_clear: busy=%b want 0", busy);
        end
        for (int i = 0; i < 4; i++) tick();
        n_vec++;
        if (ce_low_cnt != c0 || obs_q.size() != 0) begin
            n_err++;
            $display("FAIL drop_quiet: ce low cycles=%0d writes=%0d want 0 0", ce_low_cnt - c0, obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_grant_drop_reset();
        logic acc;
        wr_rec_t e, o;
        busGrant = 1'b1;
        push_req(18'h3FFFF, 16'h8001, 2'b11, acc);
        for (int i = 0; i < 10 && ram_we; i++) tick();
        busGrant = 1'b0;
        wait_idle(50);
        n_vec++;
        if ({busy, ram_ce} !== 2'b01) begin
            n_err++;
            $display("FAIL gdrop_done: busy,ce=%b want 01", {busy, ram_ce});
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL gdrop_sb: no write seen, want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL gdrop_sb: got %h want %h", o, e);
                end
            end
        end
        busGrant = 1'b1;
        push_req(18'h00100, 16'h4242, 2'b11, acc);
        for (int i = 0; i < 10 && ram_we; i++) tick();
        n_vec++;
        if (ram_we !== 1'b0) begin
            n_err++;
            $display("FAIL rst_reach_pulse: we=%b want 0", ram_we);
        end
        rstN = 1'b0;
        #1;
        n_vec++;
        if ({ram_we, ram_ce, ramDrive} !== 3'b110) begin
            n_err++;
            $display("FAIL rst_async: we,ce,drv=%b want 110", {ram_we, ram_ce, ramDrive});
        end
        @(negedge clk);
        #1;
        exp_q.delete();
        obs_q.delete();
        tick();
        rstN = 1'b1;
        tick();
        n_vec++;
        if ({wrReady, busy, ram_ce} !== 3'b101) begin
            n_err++;
            $display("FAIL rst_after: ready,busy,ce=%b want 101", {wrReady, busy, ram_ce});
        end
    endtask

`ifdef SRAM_WRITER_READBACK_EN
    task automatic test_readback();
        logic acc;
        wr_rec_t e, o;
        busGrant = 1'b1;
        din_xor  = 16'h0100;
        push_req(18'h00555, 16'h1234, 2'b01, acc);
        for (int i = 0; i < 20 && ram_oe; i++) tick();
        n_vec++;
        if ({ram_oe, ramDrive, ram_ce, ram_lb, ram_hb} !== 5'b00001) begin
            n_err++;
            $display("FAIL rb_read: oe,drv,ce,lb,hb=%b want 00001", {ram_oe, ramDrive, ram_ce, ram_lb, ram_hb});
        end
        wait_idle(50);
        n_vec++;
        if (verifyErr !== 1'b0) begin
            n_err++;
            $display("FAIL rb_lowlane: verifyErr=%b want 0", verifyErr);
        end
        push_req(18'h00556, 16'h5678, 2'b11, acc);
        wait_idle(50);
        n_vec++;
        if (verifyErr !== 1'b1) begin
            n_err++;
            $display("FAIL rb_mismatch: verifyErr=%b want 1", verifyErr);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL rb_sb: no write seen, want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL rb_sb: got %h want %h", o, e);
                end
            end
        end
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        n_vec++;
        if (verifyErr !== 1'b0) begin
            n_err++;
            $display("FAIL rb_reset: verifyErr=%b want 0", verifyErr);
        end
    endtask
`endif

    task automatic test_bus_rules();
        n_vec++;
        if (oe_drive_bad !== 1'b0) begin
            n_err++;
            $display("FAIL oe_vs_drive: oe low while driving seen=%b want 0", oe_drive_bad);
        end
    endtask

    initial begin
        rstN     = 1'b0;
        wrValid  = 1'b0;
        wrAddr   = '0;
        wrData   = '0;
        wrByteEn = 2'b00;
        busGrant = 1'b0;
        test_reset();
        test_single_write();
        test_grant_withheld();
        test_fifo_full();
        test_byte_lanes();
        test_grant_drop_reset();
`ifdef SRAM_WRITER_READBACK_EN
        test_readback();
`endif
        test_bus_rules();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish within 500000 time units");
        $fatal(1, "timeout");
    end

endmodule
